one_conv_ifm_fetcher: RTL and testbench
=======================================

# one_conv_ifm_fetcher

Producer side of the 1x1-convolution IFM stream. It reads packed IFM pixels from the on-chip IFM buffer and builds 16-lane, word-aligned windows (`temp_data_0..15`). It then presents each window with a `temp_valid`/`temp_hs` handshake to the 1x1 conv IFM controller, which extracts 13 pixels per window. Each `start` iterates over one IFM row for all column groups, OFM channel tiles and IFM channels.

## Interface
- `BRAM_AW`, default 12: IFM buffer word-address width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: one-cycle job start; ignored while `busy`=1.
- `ifm_channel`  in  11: IFM channel count C.
- `ofm_channel`  in  11: OFM channel count O.
- `ifm_width`  in  9: row width W in pixels (1..511).
- `busy`  out  1: job in progress.
- `done`  out  1: one-cycle pulse after the last window handshake.
- `ifm_rd_en`  out  1: buffer read strobe.
- `ifm_rd_addr`  out  BRAM_AW: buffer word address.
- `ifm_rd_data`  in  64: read data, valid exactly 1 cycle after `ifm_rd_en`. Bits [16k+15:16k] hold pixel 4·addr_col+k.
- `temp_valid`  out  1: window valid.
- `temp_hs`  in  1: handshake from consumer. Equals `temp_ready & temp_valid`.
- `temp_data_0..temp_data_15`  out  16 each: window lanes.

## Operation
- Derived values, latched on accepted `start`:
  - WPR = (W+3)>>2 words per channel row.
  - G = ceil(W/13) column groups.
  - R = ceil(O/16) OFM tiles.
- Window order: g outer (0..G-1), r middle (0..R-1), c inner (0..C-1). Total windows = G·R·C. Each window is re-fetched for every r; there is no caching across tiles.
- For window (g,c):
  - col_base = 13·g
  - sw = col_base>>2
  - offset = col_base mod 4
  - reads = 4 words at addr = c·WPR + sw + k, for k = 0..3
- c·WPR is built by an accumulator: +WPR per channel, cleared per r. No multiplier.
- Addresses wrap modulo 2^BRAM_AW.
- Lane mapping: word k, pixel j goes to `temp_data_{4k+j}`. Lanes whose column 4·sw+lane ≥ W are forced to 0. Words with sw+k ≥ WPR are still read but fully masked.
- Payload for the consumer is lanes offset..offset+12; its `remain` = 3-offset.
- FSM states and transitions:
  - IDLE: on `start`, go to FETCH.
  - FETCH: 4 read cycles, k = 0..3.
  - WAIT: 1 latency cycle, capturing the last word.
  - PRESENT: `temp_valid`=1 until `temp_hs`. Then go to FETCH, or to FIN if this was the last window.
  - FIN: pulse `done`, return to IDLE.
- Degenerate job: C=0 or O=0 goes straight to FIN (`done` the cycle after `start`), with no reads and no windows.
- Reset values:
  - `busy`, `done`, `ifm_rd_en`, `temp_valid` = 0.
  - `ifm_rd_addr` = 0.
  - All `temp_data` = 0.
  - FSM = IDLE, all counters = 0.
- Reset mid-job aborts immediately. No `done` is produced, and the consumer sees `temp_valid` drop.

## Timing
- Accepted `start` at cycle T:
  - `busy`=1 from T+1.
  - `ifm_rd_en`=1 at T+1..T+4.
  - Data returns at T+2..T+5.
  - `temp_valid`=1 at T+6.
- `temp_data` is stable while `temp_valid`=1 and `temp_hs`=0.
- Without prefetch, the next window's first read is at the cycle after `temp_hs`. Minimum spacing between handshakes is 6 cycles.
- `done` is asserted the cycle after the final `temp_hs`. `busy` falls in the same cycle as `done`.
- `start` arriving in the same cycle as `done` is ignored.
- `ifm_rd_en` is never asserted outside FETCH.

## Configuration
- `ONE_CONV_FETCH_PREFETCH_EN` defined:
  - Adds a second 16-lane window buffer. The next window is fetched while the current one is presented.
  - Fetch stalls only when both buffers are full.
  - After a handshake, `temp_valid` stays 1 the next cycle if the other buffer is full, enabling back-to-back windows every 5 cycles steady-state.
  - Ordering and masking are unchanged.
- Not defined: single buffer, strictly serial FETCH/WAIT/PRESENT as above.

## Test plan
- W=13, C=2, O=16, `temp_hs` held with `temp_ready`=1:
  - 2 windows, addresses 0..3 then 4..7.
  - Lanes 13..15 = 0.
  - `done` once, the cycle after the 2nd handshake.
- W=26, C=1, O=32:
  - 4 windows in order (g0r0, g0r1, g1r0, g1r1).
  - Window g=1 reads addresses 3..6 (addresses 6 and above beyond WPR=7? no: all ≤6), offset=1.
  - Lanes with col ≥ 26 = 0.
- Backpressure: consumer withholds `temp_hs` for 10 cycles. `temp_valid` and data stay constant, no extra `ifm_rd_en` (non-prefetch build), correct order after release.
- C=0: `done` at T+1, `ifm_rd_en` never asserted, `temp_valid` never asserted.
- `rst_n` low during the 3rd FETCH cycle: all outputs 0 the next cycle. A new `start` restarts at address 0.
- Prefetch build, always-ready consumer, W=416, C=4, O=16: 32·4 = 128 windows with handshake spacing ≤ 5 cycles after the first, and identical data to the non-prefetch build.

Source files
------------

// File: rtl/one_conv_ifm_fetcher.sv
// ---------------------------------------------------------------------------
// one_conv_ifm_fetcher
//
// Producer side of the 1x1-conv IFM stream. For each job it walks one IFM
// row as column groups (g, outer), OFM tiles (r, middle) and IFM channels
// (c, inner). For every (g,r,c) it reads four 64-bit IFM-buffer words and
// assembles a 16-lane window. It then hands the window to the consumer over
// a temp_valid/temp_hs handshake.
//
// Build option: define ONE_CONV_FETCH_PREFETCH_EN to add a second window
// buffer. The next window is then fetched while the current one is being
// presented. Without it the fetcher runs FETCH/WAIT/PRESENT strictly
// serially.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle job start (ignored unless idle)
//   ifm_channel       IFM channel count C
//   ofm_channel       OFM channel count O
//   ifm_width         row width W in pixels
//   busy / done       job in progress / one-cycle completion pulse
//   ifm_rd_en/_addr   IFM buffer read strobe and word address
//   ifm_rd_data       read data, valid one cycle after ifm_rd_en
//   temp_valid        window valid towards the consumer
//   temp_hs           consumer handshake (temp_ready & temp_valid)
//   temp_data_0..15   window lanes
// ---------------------------------------------------------------------------
module one_conv_ifm_fetcher #(
  parameter int BRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [10:0]        ifm_channel,
  input  logic [10:0]        ofm_channel,
  input  logic [8:0]         ifm_width,
  output logic               busy,
  output logic               done,
  output logic               ifm_rd_en,
  output logic [BRAM_AW-1:0] ifm_rd_addr,
  input  logic [63:0]        ifm_rd_data,
  output logic               temp_valid,
  input  logic               temp_hs,
  output logic [15:0]        temp_data_0,
  output logic [15:0]        temp_data_1,
  output logic [15:0]        temp_data_2,
  output logic [15:0]        temp_data_3,
  output logic [15:0]        temp_data_4,
  output logic [15:0]        temp_data_5,
  output logic [15:0]        temp_data_6,
  output logic [15:0]        temp_data_7,
  output logic [15:0]        temp_data_8,
  output logic [15:0]        temp_data_9,
  output logic [15:0]        temp_data_10,
  output logic [15:0]        temp_data_11,
  output logic [15:0]        temp_data_12,
  output logic [15:0]        temp_data_13,
  output logic [15:0]        temp_data_14,
  output logic [15:0]        temp_data_15
);

  // In the prefetch build S_PRESENT means "everything fetched, draining the
  // buffers". S_STALL (both buffers full) only exists in that build.
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_STALL, S_FIN
  } state_t;

  state_t state_reg, state_next;

  // Job parameters latched at start
  logic [10:0] chan_reg;
  logic [10:0] ofm_reg;
  logic [8:0]  width_reg;
  logic [7:0]  wpr_reg;

  // Window counters. col_base and tile base are kept as running sums so
  // that G and R never need a divider: the last group/tile is detected by
  // comparing the next base against W/O.
  logic [10:0]        c_reg;
  logic [BRAM_AW-1:0] acc_reg;     // c * WPR
  logic [11:0]        tile_reg;    // 16 * r
  logic [8:0]         colb_reg;    // 13 * g
  logic [1:0]         k_reg;

  // Read-return tracking (data valid one cycle after the strobe)
  logic       cap_en_reg;
  logic [1:0] cap_k_reg;

  logic               start_acc;
  logic               job_empty;
  logic               last_c, last_r, last_g, last_win;
  logic [11:0]        tile_plus;
  logic [9:0]         colb_plus;
  logic [BRAM_AW-1:0] fetch_addr;

  assign start_acc  = (state_reg == S_IDLE) && start;
  assign job_empty  = (ifm_channel == 11'd0) || (ofm_channel == 11'd0);
  assign tile_plus  = tile_reg + 12'd16;
  assign colb_plus  = {1'b0, colb_reg} + 10'd13;
  assign last_c     = (c_reg == chan_reg - 11'd1);
  assign last_r     = (tile_plus >= {1'b0, ofm_reg});
  assign last_g     = (colb_plus >= {1'b0, width_reg});
  assign last_win   = last_c && last_r && last_g;
  assign fetch_addr = acc_reg + BRAM_AW'(colb_reg[8:2]) + BRAM_AW'(k_reg);

`ifdef ONE_CONV_FETCH_PREFETCH_EN
  logic [1:0] full_reg;
  logic [1:0] last_buf_reg;
  logic       wr_sel_reg;
  logic       rd_sel_reg;
  logic       pf_valid;
  logic       hs_fire;
  logic       free_other;
  logic       free_wr;

  assign pf_valid = full_reg[rd_sel_reg];
  assign hs_fire  = temp_hs && pf_valid;
  // A buffer counts as free if it is empty or is being released this cycle.
  assign free_other = !full_reg[~wr_sel_reg] || (hs_fire && (rd_sel_reg == ~wr_sel_reg));
  assign free_wr    = !full_reg[wr_sel_reg]  || (hs_fire && (rd_sel_reg == wr_sel_reg));

  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      full_reg     <= 2'b00;
      last_buf_reg <= 2'b00;
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
    end else begin
      if (state_reg == S_WAIT) begin
        full_reg[wr_sel_reg]     <= 1'b1;
        last_buf_reg[wr_sel_reg] <= last_win;
        wr_sel_reg               <= ~wr_sel_reg;
      end
      if (hs_fire) begin
        full_reg[rd_sel_reg] <= 1'b0;
        rd_sel_reg           <= ~rd_sel_reg;
      end
    end
  end
`else
  logic last_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      last_reg <= 1'b0;
    end else if (state_reg == S_WAIT) begin
      last_reg <= last_win;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done        = 1'b0;
    ifm_rd_en   = 1'b0;
    ifm_rd_addr = '0;
    temp_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = job_empty ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        busy        = 1'b1;
        ifm_rd_en   = 1'b1;
        ifm_rd_addr = fetch_addr;
        if (k_reg == 2'd3) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
`ifdef ONE_CONV_FETCH_PREFETCH_EN
        if (last_win) begin
          state_next = S_PRESENT;
        end else if (free_other) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_STALL;
        end
`else
        state_next = S_PRESENT;
`endif
      end
`ifdef ONE_CONV_FETCH_PREFETCH_EN
      S_STALL: begin
        busy = 1'b1;
        if (free_wr) begin
          state_next = S_FETCH;
        end
      end
      S_PRESENT: begin
        busy = 1'b1;
        if (hs_fire && last_buf_reg[rd_sel_reg]) begin
          state_next = S_FIN;
        end
      end
`else
      S_PRESENT: begin
        busy       = 1'b1;
        temp_valid = 1'b1;
        if (temp_hs) begin
          state_next = last_reg ? S_FIN : S_FETCH;
        end
      end
`endif
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
`ifdef ONE_CONV_FETCH_PREFETCH_EN
    temp_valid = pf_valid;
`endif
  end

  // Job parameters and window counters. Counters step when a window's
  // fetch completes (WAIT), so the address for the next window is ready
  // on the following FETCH cycle in both builds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chan_reg   <= '0;
      ofm_reg    <= '0;
      width_reg  <= '0;
      wpr_reg    <= '0;
      c_reg      <= '0;
      acc_reg    <= '0;
      tile_reg   <= '0;
      colb_reg   <= '0;
      k_reg      <= '0;
    end else if (start_acc) begin
      chan_reg   <= ifm_channel;
      ofm_reg    <= ofm_channel;
      width_reg  <= ifm_width;
      wpr_reg    <= 8'(({1'b0, ifm_width} + 10'd3) >> 2);
      c_reg      <= '0;
      acc_reg    <= '0;
      tile_reg   <= '0;
      colb_reg   <= '0;
      k_reg      <= '0;
    end else begin
      if (state_reg == S_FETCH) begin
        k_reg <= k_reg + 2'd1;
      end
      if (state_reg == S_WAIT) begin
        if (!last_c) begin
          c_reg   <= c_reg + 11'd1;
          acc_reg <= acc_reg + BRAM_AW'(wpr_reg);
        end else begin
          c_reg   <= '0;
          acc_reg <= '0;
          if (!last_r) begin
            tile_reg <= tile_plus;
          end else begin
            tile_reg <= '0;
            if (!last_g) begin
              colb_reg <= colb_plus[8:0];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_en_reg <= 1'b0;
      cap_k_reg  <= 2'd0;
    end else begin
      cap_en_reg <= (state_reg == S_FETCH);
      cap_k_reg  <= k_reg;
    end
  end

  // Lane storage: lane gi holds pixel (gi%4) of word (gi/4), i.e. column
  // 4*sw+gi. Columns at or beyond W are stored as zero. This also blanks
  // whole words that lie beyond WPR.
  logic [15:0][15:0] lane_out;

  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    logic [9:0]  lane_col;
    logic        lane_hit;
    logic [15:0] lane_word;

    assign lane_col  = {1'b0, colb_reg[8:2], 2'b00} + 10'(gi);
    assign lane_hit  = cap_en_reg && (cap_k_reg == 2'(gi / 4));
    assign lane_word = (lane_col < {1'b0, width_reg}) ? ifm_rd_data[16*(gi%4) +: 16] : 16'h0;

`ifdef ONE_CONV_FETCH_PREFETCH_EN
    logic [15:0] bank0_reg;
    logic [15:0] bank1_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bank0_reg <= '0;
        bank1_reg <= '0;
      end else if (lane_hit) begin
        if (wr_sel_reg) begin
          bank1_reg <= lane_word;
        end else begin
          bank0_reg <= lane_word;
        end
      end
    end

    assign lane_out[gi] = rd_sel_reg ? bank1_reg : bank0_reg;
`else
    logic [15:0] lane_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lane_reg <= '0;
      end else if (lane_hit) begin
        lane_reg <= lane_word;
      end
    end

    assign lane_out[gi] = lane_reg;
`endif
  end

  assign temp_data_0  = lane_out[0];
  assign temp_data_1  = lane_out[1];
  assign temp_data_2  = lane_out[2];
  assign temp_data_3  = lane_out[3];
  assign temp_data_4  = lane_out[4];
  assign temp_data_5  = lane_out[5];
  assign temp_data_6  = lane_out[6];
  assign temp_data_7  = lane_out[7];
  assign temp_data_8  = lane_out[8];
  assign temp_data_9  = lane_out[9];
  assign temp_data_10 = lane_out[10];
  assign temp_data_11 = lane_out[11];
  assign temp_data_12 = lane_out[12];
  assign temp_data_13 = lane_out[13];
  assign temp_data_14 = lane_out[14];
  assign temp_data_15 = lane_out[15];

endmodule

// File: tb/tb_one_conv_ifm_fetcher.sv
// ---------------------------------------------------------------------------
// tb_one_conv_ifm_fetcher
//
// Directed bench for one_conv_ifm_fetcher (default, non-prefetch build).
// The IFM buffer is modelled as a function of the address. Pixel k of word a
// reads as 16'h8000 | a<<2 | k. Expected windows are derived from the
// window order and lane mapping of the fetcher.
// ---------------------------------------------------------------------------
module tb_one_conv_ifm_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] ifm_channel = '0;
  logic [10:0] ofm_channel = '0;
  logic [8:0]  ifm_width = '0;
  logic        busy, done, ifm_rd_en, temp_valid, temp_hs;
  logic [11:0] ifm_rd_addr;
  logic [63:0] ifm_rd_data = '0;
  logic [15:0][15:0] td;
  logic        temp_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int rd_total = 0;
  int val_cnt = 0;
  logic [11:0] rd_q[$];
  logic [255:0] last_win_obs;

  assign temp_hs = temp_ready & temp_valid;

  always #5 clk = ~clk;

  one_conv_ifm_fetcher #(.BRAM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ifm_channel(ifm_channel), .ofm_channel(ofm_channel), .ifm_width(ifm_width),
    .busy(busy), .done(done), .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .ifm_rd_data(ifm_rd_data), .temp_valid(temp_valid), .temp_hs(temp_hs),
    .temp_data_0(td[0]), .temp_data_1(td[1]), .temp_data_2(td[2]), .temp_data_3(td[3]),
    .temp_data_4(td[4]), .temp_data_5(td[5]), .temp_data_6(td[6]), .temp_data_7(td[7]),
    .temp_data_8(td[8]), .temp_data_9(td[9]), .temp_data_10(td[10]), .temp_data_11(td[11]),
    .temp_data_12(td[12]), .temp_data_13(td[13]), .temp_data_14(td[14]), .temp_data_15(td[15])
  );

  function automatic logic [15:0] pix(input int a, input int k);
    return 16'h8000 | 16'((a & 32'hfff) << 2) | 16'(k);
  endfunction

  // Buffer model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (ifm_rd_en) begin
      ifm_rd_data <= {pix(int'(ifm_rd_addr), 3), pix(int'(ifm_rd_addr), 2),
                      pix(int'(ifm_rd_addr), 1), pix(int'(ifm_rd_addr), 0)};
      rd_q.push_back(ifm_rd_addr);
      rd_total <= rd_total + 1;
    end else begin
      ifm_rd_data <= 64'hdead_beef_dead_beef;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (temp_valid) val_cnt <= val_cnt + 1;
  end

  function automatic logic [255:0] exp_win(input int w, input int wpr, input int g, input int c);
    logic [255:0] v;
    int sw, a;
    v = '0;
    sw = (13 * g) >> 2;
    for (int l = 0; l < 16; l++) begin
      a = (c * wpr + sw + l / 4) % 4096;
      if (4 * sw + l < w) v[16*l +: 16] = pix(a, l % 4);
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int w, input int c, input int o);
    ifm_width   = 9'(w);
    ifm_channel = 11'(c);
    ofm_channel = 11'(o);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge of cycle T+1; returns at the negedge of the
  // done cycle. stall > 0 withholds temp_ready for that many cycles on the
  // first window (caller clears temp_ready before start).
  task automatic run_windows(input int w, input int c_n, input int o, input int stall);
    int wpr, ng, nr, n, win, sw;
    logic [255:0] ev;
    logic [47:0] ea, oa;
    wpr = (w + 3) >> 2;
    ng  = (w + 12) / 13;
    nr  = (o + 15) / 16;
    win = 0;
    for (int g = 0; g < ng; g++) begin
      for (int r = 0; r < nr; r++) begin
        for (int c = 0; c < c_n; c++) begin
          if (win != 0) @(negedge clk);
          n = 0;
          while (!temp_valid && n < 40) begin
            @(negedge clk);
            n++;
          end
          check($sformatf("latency g%0d r%0d c%0d", g, r, c), 256'(n), 256'(5));
          sw = (13 * g) >> 2;
          ea = '0;
          oa = '0;
          for (int k = 0; k < 4; k++) begin
            ea[12*k +: 12] = 12'((c * wpr + sw + k) % 4096);
            if (k < rd_q.size()) oa[12*k +: 12] = rd_q[k];
          end
          check($sformatf("nreads g%0d r%0d c%0d", g, r, c), 256'(rd_q.size()), 256'(4));
          check($sformatf("addrs g%0d r%0d c%0d", g, r, c), 256'(oa), 256'(ea));
          rd_q.delete();
          ev = exp_win(w, wpr, g, c);
          check($sformatf("data g%0d r%0d c%0d", g, r, c), td, ev);
          last_win_obs = td;
          if (win == 0 && stall > 0) begin
            for (int i = 0; i < stall; i++) begin
              @(negedge clk);
              check("bp_valid", 256'(temp_valid), 256'(1));
              check("bp_data", td, ev);
              check("bp_noread", 256'(rd_q.size()), 256'(0));
            end
            temp_ready = 1'b1;
          end
          win++;
        end
      end
    end
    @(negedge clk);
    check("done_pulse", 256'({done, busy}), 256'(2'b10));
  endtask

  initial begin
    int d0, r0, v0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 256'({busy, done, ifm_rd_en, temp_valid, ifm_rd_addr}), 256'(0));
    check("reset_data", td, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Job 1: W=13, C=2, O=16
    rd_q.delete();
    d0 = done_cnt;
    do_start(13, 2, 16);
    check("j1_first_cycle", 256'({busy, ifm_rd_en, ifm_rd_addr}), 256'({2'b11, 12'd0}));
    run_windows(13, 2, 16, 0);
    check("j1_lane0", 256'(last_win_obs[15:0]), 256'(16'h8010));
    check("j1_lane12", 256'(last_win_obs[16*12 +: 16]), 256'(16'h801C));
    check("j1_lane13_15", 256'(last_win_obs[255:208]), 256'(0));
    // start in the done cycle must be ignored
    ifm_width = 9'd13; ifm_channel = 11'd2; ofm_channel = 11'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_ignored", 256'({busy, done, ifm_rd_en}), 256'(0));
    check("j1_done_count", 256'(done_cnt - d0), 256'(1));

    // Job 2: W=26, C=1, O=32 (two groups, two tiles)
    @(negedge clk);
    rd_q.delete();
    d0 = done_cnt;
    do_start(26, 1, 32);
    run_windows(26, 1, 32, 0);
    check("j2_g1_lane1", 256'(last_win_obs[31:16]), 256'(16'h800D));
    check("j2_g1_lane13", 256'(last_win_obs[16*13 +: 16]), 256'(16'h8019));
    check("j2_g1_lane14_15", 256'(last_win_obs[255:224]), 256'(0));
    @(negedge clk);
    check("j2_done_low", 256'(done), 256'(0));
    check("j2_done_count", 256'(done_cnt - d0), 256'(1));

    // Job 3: backpressure for 10 cycles on the first window
    rd_q.delete();
    temp_ready = 1'b0;
    do_start(13, 2, 16);
    run_windows(13, 2, 16, 10);
    @(negedge clk);

    // Job 4: C=0 and O=0 finish immediately with no activity
    r0 = rd_total;
    v0 = val_cnt;
    do_start(13, 0, 16);
    check("c0_done_t1", 256'({done, busy}), 256'(2'b10));
    @(negedge clk);
    check("c0_done_low", 256'(done), 256'(0));
    do_start(13, 2, 0);
    check("o0_done_t1", 256'({done, busy}), 256'(2'b10));
    @(negedge clk);
    check("empty_no_reads", 256'(rd_total - r0), 256'(0));
    check("empty_no_valid", 256'(val_cnt - v0), 256'(0));

    // Job 5: reset during the third FETCH cycle, then restart
    rd_q.delete();
    d0 = done_cnt;
    do_start(13, 2, 16);
    @(negedge clk);
    @(negedge clk);
    check("rst_third_fetch", 256'({ifm_rd_en, ifm_rd_addr}), 256'({1'b1, 12'd2}));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", 256'({busy, done, ifm_rd_en, temp_valid, ifm_rd_addr}), 256'(0));
    check("rst_mid_data", td, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_done", 256'(done_cnt - d0), 256'(0));
    rd_q.delete();
    do_start(13, 2, 16);
    run_windows(13, 2, 16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
